clkdiv_ctrl: RTL and testbench
==============================

// Module: clkdiv_ctrl
//
// PURPOSE
//  Run-time programmable clock-divider controller for the clk_div pin. It accepts new
//  divisors over a valid/ready handshake and applies them only at divided-period
//  boundaries, so the output never glitches. It also sequences enable and disable
//  cleanly. Sits between the config/CSR logic and the clock consumers.
//  Also drives a one-cycle tick (clock enable) aligned to each rising edge of div_clk.
//
// PARAMETERS
//  DIV_W        4   width of the divisor; legal divisors are 2 .. 2**DIV_W-1
//  DEFAULT_DIV  3   divisor loaded at reset; must be >= 2
//
// PORTS
//  clk        in   1      system clock
//  rstn       in   1      reset, synchronous, active-low
//  en         in   1      run request; 1 = divide, 0 = stop at the next period boundary
//  cfg_valid  in   1      new divisor offered
//  cfg_div    in   DIV_W  offered divisor
//  cfg_ready  out  1      controller can accept a divisor
//  cfg_err    out  1      1-cycle pulse: accepted divisor was < 2 and is discarded
//  div_clk    out  1      divided clock, registered
//  tick       out  1      1-cycle pulse on the first cycle of each divided period
//  busy       out  1      state != IDLE
//  cur_div    out  DIV_W  divisor currently in effect
//
// BEHAVIOUR
//  Reset (rstn=0 at posedge):
//   - state=IDLE, count=0, div_clk=0, tick=0, cfg_err=0, cfg_ready=1.
//   - cur_div=DEFAULT_DIV, pending slot empty.
//  Divided waveform, divisor N:
//   - count runs 0..N-1.
//   - hi_len = N - N/2 (integer division), so odd N gives high one cycle longer than low.
//   - div_clk = 1 while count < hi_len, 0 otherwise.
//   - tick = 1 only while count == 0.
//  States:
//   - IDLE: div_clk=0. When en=1 at an edge -> RUN; same edge sets count=0, div_clk=1, tick=1.
//   - RUN: count increments each edge. At the boundary (count == cur_div-1):
//     count<=0, div_clk<=1, tick<=1, and the pending divisor (if any) loads into cur_div.
//     If en=0 at an edge, go to DRAIN; the current period is not truncated.
//   - DRAIN: counting continues.
//     - At the boundary with en=0 -> IDLE, count<=0, div_clk<=0, tick stays 0.
//     - en=1 again before the boundary -> RUN, with the waveform unbroken.
//     - A pending divisor still loads at the DRAIN boundary.
//  Config handshake:
//   - A transfer occurs when cfg_valid & cfg_ready at an edge.
//   - The divisor is written to a single pending slot, and cfg_ready<=0 until the slot empties.
//   - cfg_div < 2: the transfer still completes, nothing is stored, cfg_err pulses for 1 cycle,
//     and cfg_ready stays 1.
//   - In IDLE, the pending slot loads into cur_div on the next edge; cfg_ready returns 1
//     on that same edge.
//   - In RUN/DRAIN, the slot loads at the next boundary. A transfer on the same edge as a
//     boundary is applied at the following boundary, not that one.
//  The new divisor takes effect from the first cycle of the next period. Period length
//  and hi_len never mix old and new values within one period.
//  Width: count is DIV_W bits; N <= 2**DIV_W-1, so count never wraps.
//  rstn=0 mid-period: immediate return to reset values. The pending slot is lost and
//  cur_div reverts to DEFAULT_DIV.
//
// STRUCTURE
//  - clkdiv_pkg:
//    - state_t enum {IDLE, RUN, DRAIN}
//    - function hi_len(n) returning n - n/2
//    - localparam MIN_DIV = 2
//  - Sub-module clkdiv_core (count, div_clk, tick, boundary flag; takes cur_div as input).
//  - clkdiv_ctrl holds the FSM, the pending slot, the handshake and cur_div.
//
// TESTING
//  - Reset, en=1, DEFAULT_DIV=3 -> div_clk pattern 1,1,0 repeating; tick every 3rd cycle
//    from the first RUN cycle; cur_div=3.
//  - Mid-period at count=1 with N=3, send cfg_div=4 -> cfg_ready drops for the rest of the
//    period. Next period is 1,1,0,0 with no shortened pulse, and cfg_ready returns at that
//    boundary.
//  - cfg_div=1, then cfg_div=0 -> one cfg_err pulse each, cfg_ready stays 1, and cur_div
//    is unchanged.
//  - N=5: drop en at count=1 -> period completes (1,1,1,0,0), then div_clk=0 and busy=0.
//    Repeat with en re-raised at count=3 -> waveform continues with no gap.
//  - Transfer cfg_div=6 on the exact boundary edge -> next period still uses the old N;
//    the period after uses 6.
//  - IDLE: send cfg_div=2 -> cur_div=2 one edge later.
//    Then assert rstn=0 during RUN -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the run-time programmable clock divider.
// The FSM states, the minimum legal divisor and the high-phase length rule live here.
package clkdiv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned MIN_DIV = 2;

   // Odd divisors keep the high phase one cycle longer than the low phase.
   function automatic int unsigned hi_len(input int unsigned n);
      return n - n / 2;
   endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Period counter for the divided clock: produces div_clk, the period-start tick
// and the boundary flag on the last cycle of each period.
module clkdiv_core
   import clkdiv_pkg::*;
#(
   parameter int unsigned DIV_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             active_i,
   input  logic             run_i,
   input  logic [DIV_W-1:0] cur_div_i,
   output logic             div_clk_o,
   output logic             tick_o,
   output logic             boundary_o
);

   logic [DIV_W-1:0] count_q, count_d;
   logic             div_clk_q, div_clk_d;
   logic             tick_q, tick_d;
   logic [DIV_W-1:0] count_inc;
   logic             hi_next;

   assign count_inc  = count_q + DIV_W'(1);
   assign boundary_o = active_i && (count_q == cur_div_i - DIV_W'(1));
   // cur_div_i only changes at a boundary, so every cycle of a period sees one divisor.
   assign hi_next    = 32'(count_inc) < hi_len(32'(cur_div_i));

   always_comb begin
      count_d   = count_inc;
      div_clk_d = hi_next;
      tick_d    = 1'b0;
      if (!active_i || boundary_o) begin
         // Starting a period and restarting one look the same; stopping parks low.
         count_d   = '0;
         div_clk_d = run_i;
         tick_d    = run_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q   <= '0;
         div_clk_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         div_clk_q <= div_clk_d;
         tick_q    <= tick_d;
      end
   end

   assign div_clk_o = div_clk_q;
   assign tick_o    = tick_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Clock-divider controller: run/drain/idle sequencing, divisor handshake with a
// single pending slot, and glitch-free divisor changes at period boundaries.
module clkdiv_ctrl
   import clkdiv_pkg::*;
#(
   parameter int unsigned DIV_W       = 4,
   parameter int unsigned DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             div_clk,
   output logic             tick,
   output logic             busy,
   output logic [DIV_W-1:0] cur_div
);

   state_t           state_q;
   logic [DIV_W-1:0] cur_div_q;
   logic [DIV_W-1:0] pend_div_q;
   logic             pend_vld_q;
   logic             cfg_err_q;

   logic             active;
   logic             boundary;
   logic             xfer;
   logic             div_ok;

   assign active    = (state_q != IDLE);
   assign cfg_ready = !pend_vld_q;
   assign xfer      = cfg_valid && cfg_ready;
   assign div_ok    = 32'(cfg_div) >= MIN_DIV;

   clkdiv_core #(
      .DIV_W (DIV_W)
   ) u_core (
      .clk        (clk),
      .rstn       (rstn),
      .active_i   (active),
      .run_i      (en),
      .cur_div_i  (cur_div_q),
      .div_clk_o  (div_clk),
      .tick_o     (tick),
      .boundary_o (boundary)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cur_div_q  <= DIV_W'(DEFAULT_DIV);
         pend_div_q <= '0;
         pend_vld_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         cfg_err_q <= xfer && !div_ok;

         case (state_q)
            IDLE:  if (en) state_q <= RUN;
            // A stop request landing on a boundary has nothing left to finish.
            RUN:   if (!en) state_q <= boundary ? IDLE : DRAIN;
            DRAIN: begin
               if (en)            state_q <= RUN;
               else if (boundary) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         // Slot is only written while empty, so load and store never collide.
         if (pend_vld_q && (!active || boundary)) begin
            cur_div_q  <= pend_div_q;
            pend_vld_q <= 1'b0;
         end else if (xfer && div_ok) begin
            pend_div_q <= cfg_div;
            pend_vld_q <= 1'b1;
         end
      end
   end

   assign cfg_err = cfg_err_q;
   assign busy    = active;
   assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: expected per-cycle outputs are queued as stimulus
// is applied and compared one entry per clock.
module tb_clkdiv_ctrl;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       en = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [3:0] cfg_div = 4'd0;
   logic       cfg_ready;
   logic       cfg_err;
   logic       div_clk;
   logic       tick;
   logic       busy;
   logic [3:0] cur_div;

   typedef struct {
      logic       div_clk;
      logic       tick;
      logic       busy;
      logic       cfg_ready;
      logic       cfg_err;
      logic [3:0] cur_div;
   } exp_t;

   exp_t sb_q[$];
   int   total  = 0;
   int   passed = 0;
   int   fails  = 0;
   int   cyc    = 0;

   clkdiv_ctrl #(
      .DIV_W       (4),
      .DEFAULT_DIV (3)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .div_clk   (div_clk),
      .tick      (tick),
      .busy      (busy),
      .cur_div   (cur_div)
   );

   always #5 clk = ~clk;

   // Expected outputs for position k of a period of length n (idle when bsy=0).
   task automatic push(input int n, input int k, input bit bsy, input bit rdy, input bit err);
      exp_t e;
      e.div_clk   = bsy && (k < (n - n / 2));
      e.tick      = bsy && (k == 0);
      e.busy      = bsy;
      e.cfg_ready = rdy;
      e.cfg_err   = err;
      e.cur_div   = 4'(n);
      sb_q.push_back(e);
   endtask

   task automatic push_period(input int n, input int k0, input int k1, input bit rdy);
      for (int k = k0; k <= k1; k++) push(n, k, 1'b1, rdy, 1'b0);
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         @(posedge clk);
         #1;
         cyc++;
         total++;
         assert (sb_q.size() != 0) passed++;
         else begin
            fails++;
            $error("FAIL scoreboard_empty cyc=%0d observed=0 expected=1", cyc);
         end
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("div_clk",   {3'b000, div_clk},   {3'b000, e.div_clk});
            chk("tick",      {3'b000, tick},      {3'b000, e.tick});
            chk("busy",      {3'b000, busy},      {3'b000, e.busy});
            chk("cfg_ready", {3'b000, cfg_ready}, {3'b000, e.cfg_ready});
            chk("cfg_err",   {3'b000, cfg_err},   {3'b000, e.cfg_err});
            chk("cur_div",   cur_div,             e.cur_div);
            $display("cyc %0d: div_clk=%0b tick=%0b busy=%0b cfg_ready=%0b cfg_err=%0b cur_div=%0d",
                     cyc, div_clk, tick, busy, cfg_ready, cfg_err, cur_div);
         end
      end
   endtask

   initial begin
      // Reset state
      push(3, 0, 1'b0, 1'b1, 1'b0);
      cycles(1);

      // Default divisor 3: 1,1,0 with a tick every third cycle
      rstn = 1'b1;
      en   = 1'b1;
      push_period(3, 0, 2, 1'b1);
      push_period(3, 0, 2, 1'b1);
      cycles(6);

      // Divisor 4 offered at count=1: ready low for the rest of the period
      push_period(3, 0, 1, 1'b1);
      cycles(2);
      cfg_valid = 1'b1;
      cfg_div   = 4'd4;
      push(3, 2, 1'b1, 1'b0, 1'b0);
      cycles(1);
      cfg_valid = 1'b0;
      push_period(4, 0, 3, 1'b1);
      push_period(4, 0, 3, 1'b1);
      cycles(8);

      // Illegal divisors 1 and 0: error pulse each, nothing stored
      cfg_valid = 1'b1;
      cfg_div   = 4'd1;
      push(4, 0, 1'b1, 1'b1, 1'b1);
      cycles(1);
      cfg_valid = 1'b0;
      push(4, 1, 1'b1, 1'b1, 1'b0);
      cycles(1);
      cfg_valid = 1'b1;
      cfg_div   = 4'd0;
      push(4, 2, 1'b1, 1'b1, 1'b1);
      cycles(1);
      cfg_valid = 1'b0;
      push(4, 3, 1'b1, 1'b1, 1'b0);
      cycles(1);

      // Divisor 6 transferred on the boundary edge: one more period of 4 first
      cfg_valid = 1'b1;
      cfg_div   = 4'd6;
      push(4, 0, 1'b1, 1'b0, 1'b0);
      cycles(1);
      cfg_valid = 1'b0;
      push_period(4, 1, 3, 1'b0);
      cycles(3);

      // Period of 6, with divisor 5 offered at count=1
      push_period(6, 0, 1, 1'b1);
      cycles(2);
      cfg_valid = 1'b1;
      cfg_div   = 4'd5;
      push(6, 2, 1'b1, 1'b0, 1'b0);
      cycles(1);
      cfg_valid = 1'b0;
      push_period(6, 3, 5, 1'b0);
      cycles(3);

      // N=5, en dropped at count=1: period completes then idles
      push_period(5, 0, 1, 1'b1);
      cycles(2);
      en = 1'b0;
      push_period(5, 2, 4, 1'b1);
      cycles(3);
      push(5, 0, 1'b0, 1'b1, 1'b0);
      push(5, 0, 1'b0, 1'b1, 1'b0);
      cycles(2);

      // Restart, drop en at count=1, re-raise at count=3: no gap
      en = 1'b1;
      push_period(5, 0, 1, 1'b1);
      cycles(2);
      en = 1'b0;
      push_period(5, 2, 3, 1'b1);
      cycles(2);
      en = 1'b1;
      push(5, 4, 1'b1, 1'b1, 1'b0);
      cycles(1);
      push_period(5, 0, 4, 1'b1);
      cycles(5);

      // Stop again to reach IDLE
      push(5, 0, 1'b1, 1'b1, 1'b0);
      cycles(1);
      en = 1'b0;
      push_period(5, 1, 4, 1'b1);
      cycles(4);
      push(5, 0, 1'b0, 1'b1, 1'b0);
      cycles(1);

      // Divisor 2 in IDLE: applied one edge after the transfer
      cfg_valid = 1'b1;
      cfg_div   = 4'd2;
      push(5, 0, 1'b0, 1'b0, 1'b0);
      cycles(1);
      cfg_valid = 1'b0;
      push(2, 0, 1'b0, 1'b1, 1'b0);
      cycles(1);
      en = 1'b1;
      push_period(2, 0, 1, 1'b1);
      push_period(2, 0, 1, 1'b1);
      cycles(4);

      // Leave a divisor pending, then reset mid-run: pending slot must be lost
      cfg_valid = 1'b1;
      cfg_div   = 4'd7;
      push(2, 0, 1'b1, 1'b0, 1'b0);
      cycles(1);
      cfg_valid = 1'b0;
      rstn      = 1'b0;
      push(3, 0, 1'b0, 1'b1, 1'b0);
      cycles(1);
      rstn = 1'b1;
      en   = 1'b0;
      push(3, 0, 1'b0, 1'b1, 1'b0);
      push(3, 0, 1'b0, 1'b1, 1'b0);
      cycles(2);
      en = 1'b1;
      push_period(3, 0, 2, 1'b1);
      cycles(3);
      en = 1'b0;

      total++;
      assert (sb_q.size() == 0) passed++;
      else begin
         fails++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
